// File: rtl/vessel_pkg.sv
// Shared encodings and fixed-point types for the vessel kinematics block.
package vessel_pkg;
   localparam logic [1:0] ST_WELCOME = 2'd0;
   localparam logic [1:0] ST_ORBIT   = 2'd1;
   localparam logic [1:0] ST_FLIGHT  = 2'd2;
   localparam logic [1:0] ST_LOST    = 2'd3;

   typedef enum logic [1:0] {PARK, ORBIT, FLY, HOLD} fsm_t;

   typedef logic signed [15:0] q8_8_t;
   typedef logic signed [31:0] q24_8_t;

   localparam int LUT_DEPTH = 91;
endpackage

// File: rtl/sin_quarter_lut.sv
// Registered quarter-wave sine ROM, 0..90 degrees, unsigned Q0.8 (sin 90 = 256).
module sin_quarter_lut import vessel_pkg::*; (
   input  logic       frame_clk,
   input  logic [6:0] angle,
   output logic [8:0] sin_q
);
   localparam logic [8:0] SIN_TAB [LUT_DEPTH] = '{
        0,   4,   9,  13,  18,  22,  27,  31,  36,  40,
       44,  49,  53,  58,  62,  66,  71,  75,  79,  83,
       88,  92,  96, 100, 104, 108, 112, 116, 120, 124,
      128, 132, 136, 139, 143, 147, 150, 154, 158, 161,
      165, 168, 171, 175, 178, 181, 184, 187, 190, 193,
      196, 199, 202, 204, 207, 210, 212, 215, 217, 219,
      222, 224, 226, 228, 230, 232, 234, 236, 237, 239,
      241, 242, 243, 245, 246, 247, 248, 249, 250, 251,
      252, 253, 254, 254, 255, 255, 255, 256, 256, 256,
      256
   };

   always_ff @(posedge frame_clk) begin
      sin_q <= (angle <= 7'd90) ? SIN_TAB[angle] : 9'd0;
   end
endmodule

// File: rtl/vessel_kinematics.sv
// Vessel screen position: parked, orbiting a planet at angle theta, or
// flying along the launch tangent until it leaves the screen.
module vessel_kinematics import vessel_pkg::*; #(
   parameter int ORBIT_GAP = 10,
   parameter int SPEED     = 512,
   parameter int SCREEN_W  = 640,
   parameter int SCREEN_H  = 480,
   parameter int HOME_X    = 30,
   parameter int HOME_Y    = 30
) (
   input  logic               frame_clk,
   input  logic               Reset,
   input  logic [1:0]         state,
   input  logic [2:0]         curplan,
   input  logic signed [31:0] theta,
   input  logic [7:0][9:0]    planet_x,
   input  logic [7:0][9:0]    planet_y,
   input  logic [7:0][5:0]    planet_s,
   output logic signed [31:0] VesselX,
   output logic signed [31:0] VesselY,
   output logic               pos_valid,
   output logic               lost
);
   function automatic logic signed [31:0] asr8(input logic signed [31:0] v);
      return v >>> 8;
   endfunction

   fsm_t               fsm, fsm_nxt;
   logic signed [31:0] theta_n;
   logic               theta_ok;
   logic [1:0]         q_w, q_p0, q_p1;
   logic [6:0]         a_w, a_p0;
   logic [2:0]         cp_p0;
   logic               vld_p0, vld_p1, plan_chg, orb_ok;
   logic [8:0]         s_lut_p1, c_lut_p1;
   logic signed [31:0] r_p1, cx_p1, cy_p1;
   logic signed [31:0] s_w, c_w, sin_w, cos_w, orb_x, orb_y;
   logic signed [31:0] sin_p2, cos_p2;
   q24_8_t             acc_x, acc_y, acc_x_nxt, acc_y_nxt;
   q8_8_t              vx, vy;
   logic signed [31:0] fly_x, fly_y;
   logic               fly_oob;

   // Stage 1: normalise theta, fold into quadrant and 0..89 degrees
   always_comb begin
      theta_ok = (theta >= -360) && (theta <= 719);
      theta_n  = theta;
      if (theta < 0)
         theta_n = theta + 360;
      else if (theta >= 360)
         theta_n = theta - 360;
      q_w = 2'd0;
      a_w = 7'(theta_n);
      if (theta_n >= 270) begin
         q_w = 2'd3;
         a_w = 7'(theta_n - 270);
      end else if (theta_n >= 180) begin
         q_w = 2'd2;
         a_w = 7'(theta_n - 180);
      end else if (theta_n >= 90) begin
         q_w = 2'd1;
         a_w = 7'(theta_n - 90);
      end
   end

   always_ff @(posedge frame_clk) begin
      cp_p0 <= curplan;
      if (theta_ok) begin
         q_p0 <= q_w;
         a_p0 <= a_w;
      end
   end

   assign plan_chg = (curplan != cp_p0);

   // Stage 2: quarter-wave lookup for sin(a) and cos(a) = sin(90-a)
   sin_quarter_lut u_sin_lut (
      .frame_clk (frame_clk),
      .angle     (a_p0),
      .sin_q     (s_lut_p1)
   );

   sin_quarter_lut u_cos_lut (
      .frame_clk (frame_clk),
      .angle     (7'd90 - a_p0),
      .sin_q     (c_lut_p1)
   );

   always_ff @(posedge frame_clk) begin
      q_p1  <= q_p0;
      r_p1  <= 32'(planet_s[cp_p0]) + ORBIT_GAP;
      cx_p1 <= 32'(planet_x[cp_p0]);
      cy_p1 <= 32'(planet_y[cp_p0]);
   end

   // Stage 3: signed sin/cos by quadrant, then place on the orbit circle
   always_comb begin
      s_w = $signed({23'd0, s_lut_p1});
      c_w = $signed({23'd0, c_lut_p1});
      case (q_p1)
         2'd0:    begin sin_w =  s_w; cos_w =  c_w; end
         2'd1:    begin sin_w =  c_w; cos_w = -s_w; end
         2'd2:    begin sin_w = -s_w; cos_w = -c_w; end
         default: begin sin_w = -c_w; cos_w =  s_w; end
      endcase
      orb_x = cx_p1 + asr8(r_p1 * cos_w);
      orb_y = cy_p1 - asr8(r_p1 * sin_w);
   end

   assign orb_ok = (fsm == ORBIT) && vld_p1 && !plan_chg;

   always_ff @(posedge frame_clk) begin
      if (orb_ok) begin
         sin_p2 <= sin_w;
         cos_p2 <= cos_w;
      end
   end

   always_comb begin
      acc_x_nxt = acc_x + q24_8_t'(vx);
      acc_y_nxt = acc_y + q24_8_t'(vy);
      fly_x     = asr8(acc_x_nxt);
      fly_y     = asr8(acc_y_nxt);
      fly_oob   = (fly_x < 0) || (fly_x > SCREEN_W - 1) ||
                  (fly_y < 0) || (fly_y > SCREEN_H - 1);
   end

   always_comb begin
      fsm_nxt = fsm;
      case (state)
         ST_WELCOME: fsm_nxt = PARK;
         ST_ORBIT:   fsm_nxt = ORBIT;
         ST_LOST:    fsm_nxt = HOLD;
         default: begin
            if (fsm == ORBIT)
               fsm_nxt = FLY;
            else if ((fsm == FLY) && fly_oob)
               fsm_nxt = HOLD;
         end
      endcase
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         fsm       <= PARK;
         vld_p0    <= 1'b0;
         vld_p1    <= 1'b0;
         VesselX   <= HOME_X;
         VesselY   <= HOME_Y;
         pos_valid <= 1'b0;
         lost      <= 1'b0;
         acc_x     <= '0;
         acc_y     <= '0;
         vx        <= '0;
         vy        <= '0;
      end else begin
         fsm    <= fsm_nxt;
         vld_p0 <= (fsm == ORBIT) && theta_ok;
         vld_p1 <= vld_p0 && (fsm == ORBIT) && !plan_chg;
         lost   <= 1'b0;
         case (fsm_nxt)
            PARK: begin
               VesselX   <= HOME_X;
               VesselY   <= HOME_Y;
               pos_valid <= 1'b1;
            end
            ORBIT: begin
               if (orb_ok) begin
                  VesselX <= orb_x;
                  VesselY <= orb_y;
               end
               pos_valid <= orb_ok;
            end
            FLY: begin
               pos_valid <= 1'b1;
               if (fsm == ORBIT) begin
                  acc_x <= VesselX <<< 8;
                  acc_y <= VesselY <<< 8;
                  vx    <= q8_8_t'(-asr8(sin_p2 * SPEED));
                  vy    <= q8_8_t'(-asr8(cos_p2 * SPEED));
               end else begin
                  acc_x   <= acc_x_nxt;
                  acc_y   <= acc_y_nxt;
                  VesselX <= fly_x;
                  VesselY <= fly_y;
               end
            end
            default: begin
               pos_valid <= 1'b1;
               // Escape frame: show the out-of-bounds position once and flag it
               if ((fsm == FLY) && (state == ST_FLIGHT)) begin
                  acc_x   <= acc_x_nxt;
                  acc_y   <= acc_y_nxt;
                  VesselX <= fly_x;
                  VesselY <= fly_y;
                  lost    <= 1'b1;
               end
            end
         endcase
      end
   end
endmodule

// File: doc/vessel_kinematics.md
Name: vessel_kinematics

Overview:
- Produces the vessel screen position (VesselX, VesselY) that orbitmachine consumes.
- orbitmachine's state, curplan and theta drive it, closing the loop between game FSM and vessel motion.
- Orbit mode: places the vessel on a circle around the current planet at angle theta.
- Flight mode: integrates a latched tangential velocity once per frame_clk, and flags the vessel lost when it leaves the screen.

Parameters:
- ORBIT_GAP, 10: pixels added to planet size to form orbit radius.
- SPEED, 512: flight speed, unsigned Q8.8 pixels/frame (512 = 2.0).
- SCREEN_W, 640: screen width in pixels.
- SCREEN_H, 480: screen height in pixels.
- HOME_X, 30: parked X position.
- HOME_Y, 30: parked Y position.

Ports:
- frame_clk  in  1  sole clock, one edge per frame.
- Reset  in  1  synchronous, active-high reset.
- state  in  2  orbitmachine state (0 welcome, 1 orbit, 2 flight, 3 lost).
- curplan  in  3  index of current planet.
- theta  in  32 (integer)  orbit angle in degrees.
- planet_x  in  8x10  planet centre X, indexed by curplan.
- planet_y  in  8x10  planet centre Y.
- planet_s  in  8x6  planet radius.
- VesselX  out  32 (integer)  vessel X pixel.
- VesselY  out  32 (integer)  vessel Y pixel.
- pos_valid  out  1  outputs reflect current mode.
- lost  out  1  one-cycle pulse on leaving the screen.

Interface decision: one clock; reset is synchronous and active-high; the clock port is frame_clk and the reset port is Reset.

Behaviour:
- Reset:
  - VesselX=HOME_X, VesselY=HOME_Y, pos_valid=0, lost=0.
  - Internal FSM to PARK; pipeline flushed; accumulators cleared.
- Internal FSM states: PARK, ORBIT, FLY, HOLD.
- Transitions, evaluated each frame_clk from registered state input:
  - Any -> PARK when state==0.
  - PARK/FLY/HOLD -> ORBIT when state==1 (includes capture mid-flight).
  - ORBIT -> FLY when state==2.
  - FLY -> HOLD on out-of-bounds.
  - HOLD exits only to PARK or ORBIT.
  - state==3 in any mode -> HOLD.
- PARK:
  - Outputs HOME_X/HOME_Y; pos_valid=1.
- ORBIT, 3-stage pipeline, latency 3 cycles from theta/curplan change to outputs:
  - Stage 1: normalise theta. If theta<0, add 360; if theta>=360, subtract 360; valid input range -360..719. Outside that range the stage holds previous outputs and deasserts pos_valid. Then fold into quadrant q and angle a in 0..90.
  - Stage 2: quarter-wave LUT of 91 entries, Q0.8 unsigned, sin(0)=0, sin(90)=256. Derive signed cos and sin from q. R = planet_s[curplan] + ORBIT_GAP.
  - Stage 3: VesselX = cx + ((R*cos) >>> 8) and VesselY = cy - ((R*sin) >>> 8), where cx/cy = planet_x/planet_y[curplan]. Screen Y increases downward.
  - pos_valid is 0 for the first 3 cycles after entering ORBIT, then 1.
  - The latest sin/cos are kept registered for launch.
- FLY entry, same cycle as the ORBIT->FLY transition:
  - Latch vx = -(sin*SPEED)>>>8 and vy = -(cos*SPEED)>>>8, both signed Q8.8.
  - Load accumulators (signed 24.8) with current VesselX/VesselY << 8.
- FLY, each cycle:
  - acc += v; outputs = acc >>> 8 (floor); pos_valid=1.
  - Out-of-bounds when the updated X<0 or X>SCREEN_W-1, or Y<0 or Y>SCREEN_H-1. On out-of-bounds: lost=1 for exactly one cycle, outputs frozen at the out-of-bounds value, go to HOLD.
- HOLD:
  - Outputs frozen; lost=0; pos_valid=1.
- Simultaneous events:
  - Reset wins over everything.
  - If a state change and an out-of-bounds occur in the same cycle, the state change wins and lost is not pulsed.
  - A curplan change while in ORBIT restarts the 3-cycle pipeline fill.
- Arithmetic:
  - All products are signed 32-bit.
  - Shifts are arithmetic, so results truncate toward negative infinity.

Decomposition:
- Package vessel_pkg:
  - State encoding constants ST_WELCOME=0, ST_ORBIT=1, ST_FLIGHT=2, ST_LOST=3.
  - Internal FSM enum.
  - Q8.8 fixed-point typedefs.
  - LUT depth constant 91.
- One sub-module, sin_quarter_lut:
  - Registered 91-entry ROM.
  - Input 7-bit angle 0..90, output 9-bit unsigned.
  - Forms pipeline stage 2.

Test Plan:
- Reset: Reset=1 for 2 cycles -> VesselX=30, VesselY=30, pos_valid=0, lost=0; with state=0 afterwards, pos_valid=1 and position remains (30,30).
- Orbit quadrants: planet0=(350,250) S=10, state=1, curplan=0.
  - theta=0 -> (370,250) after 3 cycles.
  - theta=90 -> (350,230).
  - theta=180 -> (330,250).
  - theta=270 -> (350,270).
  - theta=-90 and theta=630 -> (350,270).
- Launch: orbit at theta=90 then state=2 -> vx=-2, vy=0; after 10 frames VesselX=330, VesselY=230; pos_valid stays 1.
- Escape: planet (620,250) S=10 at theta=0, i.e. X=640 in orbit, then launch.
  - vx=0, vy=-2.
  - First flight cycle fails the X>639 check: lost pulses once, position frozen.
  - state=1 -> returns to orbit after 3 cycles.
- Capture and reset mid-flight:
  - During flight, set state=1 with curplan=2 (420,50,S=12) at theta=0 -> (442,50) after 3 cycles.
  - Assert Reset mid-flight -> (30,30) next cycle with pos_valid=0.
